// File: rtl/led_frame_source_pkg.sv
// Shared geometry, pixel layout and bit-reverse helper for the HUB75 framebuffer.
package led_frame_source_pkg;

    localparam int unsigned PANEL_W   = 64;
    localparam int unsigned HALF_ROWS = 32;
    localparam int unsigned CHAN_BITS = 4;

    localparam int unsigned X_W     = $clog2(PANEL_W);
    localparam int unsigned ROW_W   = $clog2(HALF_ROWS);
    localparam int unsigned PIX_W   = 3 * CHAN_BITS;
    localparam int unsigned BANK_AW = 1 + ROW_W + X_W;

    localparam int unsigned R_LSB = 2 * CHAN_BITS;
    localparam int unsigned G_LSB = CHAN_BITS;
    localparam int unsigned B_LSB = 0;

    function automatic logic [CHAN_BITS-1:0] bitrev(input logic [CHAN_BITS-1:0] v);
        logic [CHAN_BITS-1:0] r;
        for (int i = 0; i < int'(CHAN_BITS); i++) begin
            r[i] = v[CHAN_BITS-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/led_fb_bank.sv
// Simple dual-port RAM: one write port, one registered read port (block-RAM style).
module led_fb_bank #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 12
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];

    // No reset so the array and output register map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/led_frame_source.sv
// Double-buffered RGB444 framebuffer for a 64x64 HUB75 panel with frame-aligned swap
// and a 2-cycle read pipeline producing per-subframe PWM bits.
module led_frame_source
    import led_frame_source_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [X_W-1:0]   wr_x,
    input  logic [ROW_W:0]   wr_y,
    input  logic [PIX_W-1:0] wr_rgb,
    input  logic             swap_req,
    output logic             swap_pending,
    output logic             swap_done,
    input  logic             frame_start,
    input  logic             rd_en,
    input  logic [X_W-1:0]   rd_x,
    input  logic [ROW_W-1:0] rd_addr,
    input  logic [7:0]       rd_subframe,
    output logic [2:0]       rgb0,
    output logic [2:0]       rgb1,
    output logic             rd_valid
);

    logic front_sel_q, front_sel_d;
    logic swap_pending_q, swap_pending_d;
    logic swap_done_q;
    logic swap_now;

    logic                 rd_p1_q;
    logic [CHAN_BITS-1:0] cmp_q;
    logic [PIX_W-1:0]     data0, data1;
    logic [2:0]           rgb0_q, rgb1_q;
    logic                 rd_valid_q;

    logic [BANK_AW-1:0] wr_bank_addr, rd_bank_addr;

    function automatic logic [2:0] pwm_bits(input logic [PIX_W-1:0]     pix,
                                            input logic [CHAN_BITS-1:0] cmp);
        return {pix[R_LSB +: CHAN_BITS] > cmp,
                pix[G_LSB +: CHAN_BITS] > cmp,
                pix[B_LSB +: CHAN_BITS] > cmp};
    endfunction

    // Writes use the pre-swap back buffer even in the swap cycle.
    assign wr_bank_addr = {~front_sel_q, wr_y[ROW_W-1:0], wr_x};
    assign rd_bank_addr = {front_sel_q, rd_addr, rd_x};

    always_comb begin
        swap_now       = frame_start & (swap_pending_q | swap_req);
        front_sel_d    = front_sel_q ^ swap_now;
        swap_pending_d = swap_pending_q | swap_req;
        if (swap_now) begin
            swap_pending_d = 1'b0;
        end
    end

    led_fb_bank #(
        .ADDR_W (BANK_AW),
        .DATA_W (PIX_W)
    ) u_bank0 (
        .clk     (clk),
        .wr_en   (wr_en & ~wr_y[ROW_W]),
        .wr_addr (wr_bank_addr),
        .wr_data (wr_rgb),
        .rd_en   (rd_en),
        .rd_addr (rd_bank_addr),
        .rd_data (data0)
    );

    led_fb_bank #(
        .ADDR_W (BANK_AW),
        .DATA_W (PIX_W)
    ) u_bank1 (
        .clk     (clk),
        .wr_en   (wr_en & wr_y[ROW_W]),
        .wr_addr (wr_bank_addr),
        .wr_data (wr_rgb),
        .rd_en   (rd_en),
        .rd_addr (rd_bank_addr),
        .rd_data (data1)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            front_sel_q    <= 1'b0;
            swap_pending_q <= 1'b0;
            swap_done_q    <= 1'b0;
            rd_p1_q        <= 1'b0;
            cmp_q          <= '0;
            rgb0_q         <= '0;
            rgb1_q         <= '0;
            rd_valid_q     <= 1'b0;
        end else begin
            front_sel_q    <= front_sel_d;
            swap_pending_q <= swap_pending_d;
            swap_done_q    <= swap_now;
            rd_p1_q        <= rd_en;
            if (rd_en) begin
                cmp_q <= bitrev(rd_subframe[CHAN_BITS-1:0]);
            end
            rd_valid_q <= rd_p1_q;
            // Outputs hold their last value when no read completes.
            if (rd_p1_q) begin
                rgb0_q <= pwm_bits(data0, cmp_q);
                rgb1_q <= pwm_bits(data1, cmp_q);
            end
        end
    end

    assign swap_pending = swap_pending_q;
    assign swap_done    = swap_done_q;
    assign rgb0         = rgb0_q;
    assign rgb1         = rgb1_q;
    assign rd_valid     = rd_valid_q;

endmodule

// File: tb/tb_led_frame_source.sv
// Scoreboard bench for led_frame_source: a behavioural framebuffer model predicts each read.
module tb_led_frame_source;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [5:0]  wr_x = '0;
    logic [5:0]  wr_y = '0;
    logic [11:0] wr_rgb = '0;
    logic        swap_req = 1'b0;
    logic        frame_start = 1'b0;
    logic        rd_en = 1'b0;
    logic [5:0]  rd_x = '0;
    logic [4:0]  rd_addr = '0;
    logic [7:0]  rd_subframe = '0;
    logic        swap_pending, swap_done, rd_valid;
    logic [2:0]  rgb0, rgb1;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    led_frame_source dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_en        (wr_en),
        .wr_x         (wr_x),
        .wr_y         (wr_y),
        .wr_rgb       (wr_rgb),
        .swap_req     (swap_req),
        .swap_pending (swap_pending),
        .swap_done    (swap_done),
        .frame_start  (frame_start),
        .rd_en        (rd_en),
        .rd_x         (rd_x),
        .rd_addr      (rd_addr),
        .rd_subframe  (rd_subframe),
        .rgb0         (rgb0),
        .rgb1         (rgb1),
        .rd_valid     (rd_valid)
    );

    typedef struct {
        logic [2:0] r0;
        logic [2:0] r1;
    } exp_t;

    exp_t        sb[$];
    exp_t        m_e;
    logic [11:0] m_mem0 [0:8191];
    logic [11:0] m_mem1 [0:8191];
    logic        m_front, m_pend, m_done, m_now, m_v1, m_v2;

    function automatic logic [2:0] model_pwm(input logic [11:0] p, input logic [7:0] s);
        logic [3:0] c;
        c = {s[0], s[1], s[2], s[3]};
        return {p[11:8] > c, p[7:4] > c, p[3:0] > c};
    endfunction

    // Reference model, updated on the same edge the DUT samples its inputs.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_front = 1'b0;
            m_pend  = 1'b0;
            m_done  = 1'b0;
            m_v1    = 1'b0;
            m_v2    = 1'b0;
            sb.delete();
        end else begin
            m_v2 = m_v1;
            m_v1 = rd_en;
            if (rd_en) begin
                m_e.r0 = model_pwm(m_mem0[{m_front, rd_addr, rd_x}], rd_subframe);
                m_e.r1 = model_pwm(m_mem1[{m_front, rd_addr, rd_x}], rd_subframe);
                sb.push_back(m_e);
            end
            if (wr_en) begin
                if (wr_y[5]) m_mem1[{~m_front, wr_y[4:0], wr_x}] = wr_rgb;
                else         m_mem0[{~m_front, wr_y[4:0], wr_x}] = wr_rgb;
            end
            m_now  = frame_start && (m_pend || swap_req);
            m_done = m_now;
            if (m_now) begin
                m_front = ~m_front;
                m_pend  = 1'b0;
            end else if (swap_req) begin
                m_pend = 1'b1;
            end
        end
    end

    task automatic monitor();
        exp_t       e;
        logic [2:0] last0 = '0;
        logic [2:0] last1 = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                last0 = '0;
                last1 = '0;
            end else begin
                n_checks++;
                if (rd_valid !== m_v2) begin
                    n_fail++;
                    $display("FAIL rd_valid: got %b expected %b at %0t", rd_valid, m_v2, $time);
                end
                if (m_v2) begin
                    n_checks++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_empty: no expected entry at %0t", $time);
                    end else begin
                        e = sb.pop_front();
                        if (rgb0 !== e.r0 || rgb1 !== e.r1) begin
                            n_fail++;
                            $display("FAIL read_data: got rgb0=%b rgb1=%b expected %b %b at %0t",
                                     rgb0, rgb1, e.r0, e.r1, $time);
                        end
                        last0 = e.r0;
                        last1 = e.r1;
                    end
                end else begin
                    n_checks++;
                    if (rgb0 !== last0 || rgb1 !== last1) begin
                        n_fail++;
                        $display("FAIL hold: got rgb0=%b rgb1=%b expected %b %b at %0t",
                                 rgb0, rgb1, last0, last1, $time);
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_px(input logic [5:0] x, input logic [5:0] y, input logic [11:0] rgb);
        wr_en = 1'b1; wr_x = x; wr_y = y; wr_rgb = rgb;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_swap();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic drain();
        rd_en = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (rgb0 !== 3'b000 || rgb1 !== 3'b000 || rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out: got rgb0=%b rgb1=%b rd_valid=%b expected 0 0 0",
                     rgb0, rgb1, rd_valid);
        end
        n_checks++;
        if (swap_pending !== 1'b0 || swap_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_swap: got pending=%b done=%b expected 0 0",
                     swap_pending, swap_done);
        end
        reset_n = 1'b1;
        tick();
    endtask

    // Fill both buffers completely so no read can return uninitialised RAM.
    task automatic fill_buffers();
        for (int b = 0; b < 2; b++) begin
            for (int y = 0; y < 64; y++) begin
                for (int x = 0; x < 64; x++) begin
                    wr_en = 1'b1; wr_x = 6'(x); wr_y = 6'(y); wr_rgb = 12'($urandom);
                    tick();
                end
            end
            wr_en = 1'b0;
            do_swap();
        end
    endtask

    task automatic test_basic();
        int dones;
        write_px(6'd5, 6'd3, 12'hF00);
        write_px(6'd5, 6'd35, 12'h00F);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        n_checks++;
        if (swap_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_pending: got %b expected 1", swap_pending);
        end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        dones = (swap_done === 1'b1) ? 1 : 0;
        n_checks++;
        if (swap_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pending_clr: got %b expected 0", swap_pending);
        end
        for (int s = 0; s < 16; s++) begin
            rd_en = 1'b1; rd_addr = 5'd3; rd_x = 6'd5; rd_subframe = 8'(s);
            tick();
            if (swap_done === 1'b1) dones++;
        end
        rd_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (swap_done === 1'b1) dones++;
        end
        n_checks++;
        if (dones != 1) begin
            n_fail++;
            $display("FAIL basic_swap_done: got %0d pulses expected 1", dones);
        end
    endtask

    task automatic test_duty_lsb();
        write_px(6'd9, 6'd4, 12'h100);
        write_px(6'd9, 6'd36, 12'h000);
        do_swap();
        for (int s = 0; s < 16; s++) begin
            rd_en = 1'b1; rd_addr = 5'd4; rd_x = 6'd9; rd_subframe = {4'hA, 4'(s)};
            tick();
        end
        drain();
    endtask

    task automatic test_no_swap();
        write_px(6'd9, 6'd4, 12'h0F0);
        write_px(6'd9, 6'd36, 12'hFFF);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        n_checks++;
        if (swap_pending !== 1'b0 || swap_done !== 1'b0) begin
            n_fail++;
            $display("FAIL no_swap: got pending=%b done=%b expected 0 0", swap_pending, swap_done);
        end
        for (int s = 0; s < 4; s++) begin
            rd_en = 1'b1; rd_addr = 5'd4; rd_x = 6'd9; rd_subframe = 8'(s);
            tick();
        end
        drain();
    endtask

    task automatic test_multi_swap();
        int dones = 0;
        for (int i = 1; i <= 4; i++) begin
            swap_req = 1'b1;
            wr_en = 1'b1; wr_x = 6'(i); wr_y = 6'd2; wr_rgb = 12'($urandom);
            tick();
            n_checks++;
            if (swap_pending !== 1'b1) begin
                n_fail++;
                $display("FAIL multi_pending: got %b expected 1 (req %0d)", swap_pending, i);
            end
        end
        swap_req = 1'b0;
        frame_start = 1'b1;
        wr_x = 6'd5; wr_rgb = 12'($urandom);
        tick();
        frame_start = 1'b0;
        if (swap_done === 1'b1) dones++;
        wr_x = 6'd6; wr_rgb = 12'($urandom);
        tick();
        wr_en = 1'b0;
        if (swap_done === 1'b1) dones++;
        n_checks++;
        if (swap_pending !== 1'b0 || dones != 1) begin
            n_fail++;
            $display("FAIL multi_toggle: got pending=%b pulses=%0d expected 0 1",
                     swap_pending, dones);
        end
        for (int x = 1; x <= 5; x++) begin
            for (int s = 0; s < 16; s++) begin
                rd_en = 1'b1; rd_addr = 5'd2; rd_x = 6'(x); rd_subframe = 8'(s);
                tick();
            end
        end
        drain();
        do_swap();
        for (int s = 0; s < 16; s++) begin
            rd_en = 1'b1; rd_addr = 5'd2; rd_x = 6'd6; rd_subframe = 8'(s);
            tick();
        end
        drain();
    endtask

    task automatic test_swap_mid_burst();
        write_px(6'd20, 6'd10, 12'h000);
        write_px(6'd20, 6'd42, 12'h000);
        do_swap();
        write_px(6'd20, 6'd10, 12'hFFF);
        write_px(6'd20, 6'd42, 12'hFFF);
        for (int i = 0; i < 12; i++) begin
            rd_en = 1'b1; rd_addr = 5'd10; rd_x = 6'd20; rd_subframe = 8'(i);
            swap_req = (i == 6); frame_start = (i == 6);
            tick();
            if (i == 6) begin
                n_checks++;
                if (swap_done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL burst_swap_done: got %b expected 1", swap_done);
                end
            end
        end
        swap_req = 1'b0; frame_start = 1'b0;
        drain();
    endtask

    task automatic test_reset_mid_burst();
        if (m_front) do_swap();
        write_px(6'd1, 6'd30, 12'hFFF);
        write_px(6'd1, 6'd62, 12'hFFF);
        do_swap();
        write_px(6'd1, 6'd30, 12'h000);
        write_px(6'd1, 6'd62, 12'h000);
        for (int i = 0; i < 4; i++) begin
            rd_en = 1'b1; rd_addr = 5'd30; rd_x = 6'd1; rd_subframe = 8'd0;
            swap_req = (i == 0);
            tick();
        end
        swap_req = 1'b0;
        #2;
        reset_n = 1'b0;
        rd_en = 1'b0;
        #1;
        n_checks++;
        if (rgb0 !== 3'b000 || rgb1 !== 3'b000 || rd_valid !== 1'b0 || swap_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got rgb0=%b rgb1=%b valid=%b pending=%b expected 0 0 0 0",
                     rgb0, rgb1, rd_valid, swap_pending);
        end
        tick();
        reset_n = 1'b1;
        tick();
        rd_en = 1'b1; rd_addr = 5'd30; rd_x = 6'd1; rd_subframe = 8'd0;
        tick();
        rd_en = 1'b0;
        n_checks++;
        if (rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_early: got rd_valid=%b expected 0", rd_valid);
        end
        tick();
        n_checks++;
        if (rd_valid !== 1'b1 || rgb0 !== 3'b000 || rgb1 !== 3'b000) begin
            n_fail++;
            $display("FAIL post_reset_read: got valid=%b rgb0=%b rgb1=%b expected 1 000 000",
                     rd_valid, rgb0, rgb1);
        end
        drain();
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        fill_buffers();
        test_basic();
        test_duty_lsb();
        test_no_swap();
        test_multi_swap();
        test_swap_mid_burst();
        test_reset_mid_burst();
        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_frame_source.md
Name: led_frame_source

Overview:
- Double-buffered RGB444 framebuffer for the 64x64 HUB75 panel. Sits directly upstream of the panel scan/shift driver.
- A host-side writer fills the back buffer. A swap is requested by the host and takes effect only at the driver's frame boundary.
- The driver reads both half-panel pixels for (row addr, column x) each shift cycle. The block returns per-channel PWM bits for the given subframe.
- The LSB-first bit-reversed compare moves here from the driver.

Parameters:
- PANEL_W, 64, columns per row (power of two)
- HALF_ROWS, 32, rows per half panel (scan addresses)
- CHAN_BITS, 4, bits per colour channel; pixel word = 3*CHAN_BITS

Ports:
- clk  in  1  single clock (30 MHz domain)
- reset_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write strobe, one pixel per cycle
- wr_x  in  6  write column
- wr_y  in  6  write row; wr_y[5] selects lower half
- wr_rgb  in  12  pixel {R[3:0],G[3:0],B[3:0]}
- swap_req  in  1  single-cycle request to swap front/back at next frame_start
- swap_pending  out  1  high from request until swap executes
- swap_done  out  1  one-cycle pulse on the cycle after the swap executes
- frame_start  in  1  one-cycle pulse from driver at start of row 0 of a frame
- rd_en  in  1  read request
- rd_x  in  6  read column
- rd_addr  in  5  scan row address
- rd_subframe  in  8  driver subframe counter; low CHAN_BITS used
- rgb0  out  3  {r,g,b} PWM bits for row rd_addr
- rgb1  out  3  {r,g,b} PWM bits for row rd_addr+32
- rd_valid  out  1  rgb0/rgb1 valid for the matching request

Behaviour:
- Reset (async assert, sync release):
  - front_sel=0; swap_pending=0; swap_done=0.
  - rgb0=rgb1=0; rd_valid=0; read pipeline flushed.
  - RAM contents are not cleared; the first frame is undefined until written.
- Storage:
  - Two banks, one per half panel. Each is 2*HALF_ROWS*PANEL_W words x 12 bits.
  - Bank address = {buffer, row[4:0], x[5:0]}.
- Write:
  - On wr_en, write wr_rgb to bank wr_y[5], address {~front_sel, wr_y[4:0], wr_x}.
  - Writes always target the back buffer; there is no back-pressure.
- Swap:
  - swap_req sets swap_pending.
  - On frame_start with swap_pending (or swap_req in the same cycle): front_sel toggles, swap_pending clears, swap_done pulses the following cycle.
  - wr_en in the swap cycle uses the pre-swap back buffer.
  - swap_req while pending is ignored; there is no double toggle.
  - frame_start without a pending swap has no effect.
- Read pipeline, fixed 2-cycle latency:
  - Cycle N, rd_en: both banks are addressed with {front_sel, rd_addr, rd_x}. The low CHAN_BITS of rd_subframe are captured bit-reversed as cmp.
  - Cycle N+1: registered RAM data.
  - Cycle N+2: each output bit = channel > cmp (unsigned). rgb0 comes from bank 0 and rgb1 from bank 1. rd_valid=1.
  - Without rd_en, rd_valid=0 at N+2 and rgb0/rgb1 hold their last values.
  - Back-to-back rd_en every cycle is fully supported.
- Swap during in-flight reads: front_sel is sampled at cycle N, so in-flight reads complete from the old buffer.
- Read/write same address same cycle: the two always hit different buffers, so there is no hazard.
- Duty cycle: channel value v gives v/16 subframes lit. 0 is never lit; 15 is lit 15/16.

Decomposition:
- Shared package holds:
  - PANEL_W, HALF_ROWS, CHAN_BITS
  - pixel word width and field offsets (R/G/B slices)
  - the bit-reverse function, also used by the driver and testbench.
- One sub-module, led_fb_bank: simple dual-port RAM, one write port, one registered read port, inferred to EBR. Instantiated twice.

Test Plan:
- Write pixel (x=5,y=3)=12'hF00 and (x=5,y=35)=12'h00F, swap_req, frame_start; read addr=3,x=5 for subframes 0..15 -> rgb0=3'b100 on 15 of 16 subframes, rgb1=3'b001 on 15 of 16; swap_done pulses once; rd_valid exactly 2 cycles after each rd_en.
- Value 12'h100 (R=1): sweep subframe 0..15 -> r lit only when bitrev(sub[3:0])==0, i.e. subframe 0 only; value 0 never lit.
- Write back buffer without swap_req, then frame_start -> reads still return the old front contents; swap_pending=0; no swap_done.
- swap_req, then 3 further swap_req and wr_en continuing, then one frame_start -> exactly one toggle; writes before and in the swap cycle land in the new front; later writes land in the new back.
- Continuous rd_en with frame_start+swap mid-burst -> reads issued before the swap cycle return old-buffer data, reads after return new-buffer data, no bubble in rd_valid.
- Assert reset_n low mid-burst with swap pending -> outputs 0 and swap_pending=0 immediately (async); after release, front_sel=0 and the first rd_valid appears 2 cycles after the first rd_en.
